// File: rtl/unary_dot_mac_if.sv
// rtl/unary_dot_mac_if.sv - operand/result bundle for the unary dot-product MAC
//
// Purpose: groups the frame-start, operand streams and result signals of
// unary_dot_mac so they travel as one port.
// Signals:
//   start        frame start (master -> slave)
//   a, b         per-lane unary operand streams (master -> slave)
//   c            unary addend stream (master -> slave)
//   acc_en       accumulate select, sampled with start (master -> slave)
//   busy         engine not idle (slave -> master)
//   out          unary result stream (slave -> master)
//   out_last     marks the final 1 of out (slave -> master)
//   result       binary result (slave -> master)
//   result_valid one-cycle pulse on result update (slave -> master)
interface unary_dot_mac_if #(
  parameter int LANES    = 2,
  parameter int RES_BITS = 12
);
  logic                start;
  logic [LANES-1:0]    a;
  logic [LANES-1:0]    b;
  logic                c;
  logic                acc_en;
  logic                busy;
  logic                out;
  logic                out_last;
  logic [RES_BITS-1:0] result;
  logic                result_valid;

  modport master (
    output start, a, b, c, acc_en,
    input  busy, out, out_last, result, result_valid
  );

  modport slave (
    input  start, a, b, c, acc_en,
    output busy, out, out_last, result, result_valid
  );
endinterface

// File: rtl/unary_dot_mac.sv
// rtl/unary_dot_mac.sv - multi-lane unary multiply-accumulate (dot product)
//
// Purpose: counts ones in LANES pairs of unary operand frames plus an addend
// frame, multiplies each pair with a shift-add multiplier, sums the products
// with the addend (or the previous result), saturates, and returns the value
// as a binary bus and as a unary output stream.
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      unary_dot_mac_if slave: start/a/b/c/acc_en in,
//            busy/out/out_last/result/result_valid out
module unary_dot_mac #(
  parameter int BIN_BITS = 4,
  parameter int LANES    = 2,
  parameter int RES_BITS = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  unary_dot_mac_if.slave  bus
);
  localparam int U_BITS = 1 << BIN_BITS;
  localparam int CW     = BIN_BITS + 1;
  localparam int PW     = 2 * CW;
  localparam int SW     = ((RES_BITS > PW) ? RES_BITS : PW) + $clog2(LANES + 1) + 1;
  localparam logic [CW-1:0]       CAP_LAST = CW'(U_BITS - 1);
  localparam logic [CW-1:0]       MUL_LAST = CW'(CW - 1);
  localparam logic [RES_BITS-1:0] RES_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_MULT, S_SUM, S_EMIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cyc;
  logic [CW-1:0]       r_acnt [LANES];
  logic [CW-1:0]       r_bcnt [LANES];
  logic [CW-1:0]       r_ccnt;
  logic [PW-1:0]       r_prod [LANES];
  logic                r_acc;
  logic [RES_BITS-1:0] r_result;
  logic [RES_BITS-1:0] r_rem;
  logic                r_valid;
  logic                r_out;
  logic                r_last;
  logic [SW-1:0]       w_sum;
  logic [RES_BITS-1:0] w_sat;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_CAPTURE;
      S_CAPTURE: if (r_cyc == CAP_LAST) w_next = S_MULT;
      S_MULT:    if (r_cyc == MUL_LAST) w_next = S_SUM;
      S_SUM:     w_next = S_EMIT;
      // r_rem holds the out cycles still owed including this one
      S_EMIT:    if (r_rem <= RES_BITS'(1)) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sum = r_acc ? SW'(r_result) : SW'(r_ccnt);
    for (int l = 0; l < LANES; l++) w_sum = w_sum + SW'(r_prod[l]);
    w_sat = (w_sum > SW'(RES_MAX)) ? RES_MAX : w_sum[RES_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cyc    <= '0;
      r_ccnt   <= '0;
      r_acc    <= 1'b0;
      r_result <= '0;
      r_rem    <= '0;
      r_valid  <= 1'b0;
      r_out    <= 1'b0;
      r_last   <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_acnt[l] <= '0;
        r_bcnt[l] <= '0;
        r_prod[l] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // the start cycle is frame cycle 0, so its bits count
            r_cyc  <= CW'(1);
            r_ccnt <= CW'(bus.c);
            r_acc  <= bus.acc_en;
            for (int l = 0; l < LANES; l++) begin
              r_acnt[l] <= CW'(bus.a[l]);
              r_bcnt[l] <= CW'(bus.b[l]);
              r_prod[l] <= '0;
            end
          end
        end
        S_CAPTURE: begin
          r_cyc  <= (r_cyc == CAP_LAST) ? '0 : r_cyc + CW'(1);
          r_ccnt <= r_ccnt + CW'(bus.c);
          for (int l = 0; l < LANES; l++) begin
            r_acnt[l] <= r_acnt[l] + CW'(bus.a[l]);
            r_bcnt[l] <= r_bcnt[l] + CW'(bus.b[l]);
          end
        end
        S_MULT: begin
          // b is consumed LSB first; a is weighted by the current bit index
          r_cyc <= (r_cyc == MUL_LAST) ? '0 : r_cyc + CW'(1);
          for (int l = 0; l < LANES; l++) begin
            if (r_bcnt[l][0]) r_prod[l] <= r_prod[l] + (PW'(r_acnt[l]) << r_cyc);
            r_bcnt[l] <= r_bcnt[l] >> 1;
          end
        end
        S_SUM: begin
          r_result <= w_sat;
          r_valid  <= 1'b1;
          r_rem    <= w_sat;
          r_out    <= (w_sat != '0);
          r_last   <= (w_sat == RES_BITS'(1));
        end
        S_EMIT: begin
          if (r_rem != '0) r_rem <= r_rem - RES_BITS'(1);
          if (r_rem <= RES_BITS'(1)) begin
            r_out  <= 1'b0;
            r_last <= 1'b0;
          end else begin
            r_out  <= 1'b1;
            r_last <= (r_rem == RES_BITS'(2));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.out          = r_out;
  assign bus.out_last     = r_last;
  assign bus.result       = r_result;
  assign bus.result_valid = r_valid;
endmodule

// File: tb/tb_unary_dot_mac.sv
// tb/tb_unary_dot_mac.sv - self-checking bench for unary_dot_mac
module tb_unary_dot_mac;
  localparam int T = 22;
  localparam int MAXR = 4095;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  int   exp_prev;
  logic [15:0] pat_a [2];
  logic [15:0] pat_b [2];
  logic [15:0] pat_c;

  unary_dot_mac_if #(.LANES(2), .RES_BITS(12)) bus ();

  unary_dot_mac #(.BIN_BITS(4), .LANES(2), .RES_BITS(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic set_pats(input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] b0, input logic [15:0] b1,
                          input logic [15:0] c);
    pat_a[0] = a0; pat_a[1] = a1; pat_b[0] = b0; pat_b[1] = b1; pat_c = c;
  endtask

  // Pattern bit 15 is frame cycle 0. Returns in the cycle busy is expected low
  // (or the cycle after a reset), without advancing the clock, so the next frame
  // may start in that very cycle.
  task automatic run_frame(input bit acc, input int busy_start, input int rst_at);
    int r, s, end_cyc, emit_len;
    bit after_rst;
    logic eb, eo, el, ev;
    int eres;
    s = $countones(pat_a[0]) * $countones(pat_b[0]) + $countones(pat_a[1]) * $countones(pat_b[1]);
    r = (acc ? exp_prev : $countones(pat_c)) + s;
    if (r > MAXR) r = MAXR;
    emit_len = (r == 0) ? 1 : r;
    end_cyc  = (rst_at >= 0) ? rst_at + 1 : T + emit_len;
    for (int cyc = 0; cyc <= end_cyc; cyc++) begin
      bus.start = (cyc == 0 || cyc == busy_start) && cyc != end_cyc;
      for (int l = 0; l < 2; l++) begin
        bus.a[l] = (cyc < 16) ? pat_a[l][15-cyc] : 1'($urandom_range(0, 1));
        bus.b[l] = (cyc < 16) ? pat_b[l][15-cyc] : 1'($urandom_range(0, 1));
      end
      bus.c      = (cyc < 16) ? pat_c[15-cyc] : 1'($urandom_range(0, 1));
      bus.acc_en = (cyc == 0) ? acc : 1'($urandom_range(0, 1));
      reset_n    = !(cyc == rst_at);
      after_rst  = (rst_at >= 0) && (cyc > rst_at);
      if (after_rst) begin
        eb = 0; eo = 0; el = 0; ev = 0; eres = 0;
      end else begin
        eb   = (cyc >= 1) && (cyc < T + emit_len);
        eo   = (r > 0) && (cyc >= T) && (cyc < T + r);
        el   = (r > 0) && (cyc == T + r - 1);
        ev   = (cyc == T);
        eres = (cyc >= T) ? r : exp_prev;
      end
      chk("busy", cyc, 32'(bus.busy), 32'(eb));
      chk("out", cyc, 32'(bus.out), 32'(eo));
      chk("out_last", cyc, 32'(bus.out_last), 32'(el));
      chk("result_valid", cyc, 32'(bus.result_valid), 32'(ev));
      chk("result", cyc, 32'(bus.result), 32'(eres));
      if (cyc != end_cyc) begin
        @(posedge clk);
        #1;
      end
    end
    bus.start = 1'b0;
    reset_n   = 1'b1;
    exp_prev  = (rst_at >= 0) ? 0 : r;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_prev = 0;
    reset_n  = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = 1'b0; bus.acc_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 0, 32'(bus.busy), 32'd0);
    chk("rst_out", 0, 32'(bus.out), 32'd0);
    chk("rst_out_last", 0, 32'(bus.out_last), 32'd0);
    chk("rst_result", 0, 32'(bus.result), 32'd0);
    chk("rst_valid", 0, 32'(bus.result_valid), 32'd0);
    reset_n = 1'b1;

    // basic: 3*5 + 2*4 + 7 = 30
    set_pats(16'hE000, 16'hC000, 16'hF800, 16'hF000, 16'hFE00);
    run_frame(1'b0, -1, -1);
    // accumulate: 30 + 1, c ignored
    set_pats(16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'hFF80);
    run_frame(1'b1, -1, -1);
    // all zero
    set_pats(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_frame(1'b0, -1, -1);
    // non-thermometer a0 (4 ones) * 2, with an ignored start at cycle 10
    set_pats(16'hAA00, 16'h0000, 16'hC000, 16'h0000, 16'h0000);
    run_frame(1'b0, 10, -1);
    // result of exactly one
    set_pats(16'h0100, 16'h0000, 16'h0010, 16'h0000, 16'h0000);
    run_frame(1'b0, -1, -1);
    // random frames
    for (int i = 0; i < 5; i++) begin
      set_pats(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
      run_frame(1'($urandom_range(0, 1)), (i == 2) ? 20 : -1, -1);
    end
    // reset during EMIT of the basic case
    set_pats(16'hE000, 16'hC000, 16'hF800, 16'hF000, 16'hFE00);
    run_frame(1'b0, -1, 30);
    // accumulate right after reset: previous result must read as 0
    set_pats(16'hE000, 16'h0000, 16'hF800, 16'h0000, 16'hFFFF);
    run_frame(1'b1, -1, -1);
    // saturation chain: 528, +512 per frame, then clamp at 4095
    set_pats(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_frame(1'b0, -1, -1);
    for (int i = 0; i < 7; i++) run_frame(1'b1, -1, -1);
    chk("saturated", 0, 32'(exp_prev), 32'd4095);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
